// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mem_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: load-use, multiply hold, data-memory wait
// and redirect flush, with saturating performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic             D_use_rs1,
  input  logic             D_use_rs2,
  input  logic             EX_ld,
  input  logic [4:0]       EX_rd,
  input  logic             EX_mul,
  input  logic             EX_taken,
  input  logic             M_req,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_FD,
  output logic             MEM_stall,
  output logic [CNT_W-1:0] cnt_freeze,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int              MC_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MUL_INIT = MC_W'(MUL_LAT - 1);
  localparam logic            MUL_EN   = (MUL_LAT > 1);

  mem_state_e      mem_state, mem_next;
  logic            mem_frz;
  logic [MC_W-1:0] mul_cnt, mul_eff;
  logic            mul_done, mul_load, mul_frz;
  logic            frz, lu;
  logic [CNT_W-1:0] frz_count, bub_count, fl_count;

  // Memory wait FSM; M_DONE holds off re-issue until the whole pipe unfreezes.
  always_comb begin
    mem_next = mem_state;
    mem_frz  = 1'b0;
    case (mem_state)
      M_IDLE: begin
        if (M_req && !dmem_ready) begin
          mem_frz  = 1'b1;
          mem_next = M_WAIT;
        end
      end
      M_WAIT: begin
        mem_frz = 1'b1;
        if (dmem_ready) mem_next = M_DONE;
      end
      M_DONE: begin
        if (!mul_frz) mem_next = M_IDLE;
      end
      default: mem_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) mem_state <= M_IDLE;
    else     mem_state <= mem_next;
  end

  // The load cycle counts as the first hold cycle, so the hold is MUL_LAT-1.
  assign mul_load = MUL_EN && EX_mul && (mul_cnt == '0) && !mul_done;
  assign mul_eff  = mul_load ? MUL_INIT : mul_cnt;
  assign mul_frz  = (mul_eff != '0);
  assign frz      = mem_frz | mul_frz;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt  <= '0;
      mul_done <= 1'b0;
    end else begin
      mul_cnt <= mul_frz ? (mul_eff - MC_W'(1)) : '0;
      if (mul_eff == MC_W'(1)) mul_done <= 1'b1;
      else if (!frz)           mul_done <= 1'b0;
    end
  end

  assign lu = EX_ld && (EX_rd != REG_ZERO) &&
              ((D_use_rs1 && (D_rs1 == EX_rd)) || (D_use_rs2 && (D_rs2 == EX_rd)));

  // Freeze dominates redirect, redirect dominates load-use.
  assign MEM_stall = !rst && frz;
  assign flush_FD  = !rst && EX_taken && !frz;
  assign stall_D   = !rst && (lu || EX_taken) && !frz;
  assign stall_F   = !rst && lu && !EX_taken && !frz;

  sat_counter #(.W(CNT_W)) u_cnt_freeze (
    .clk   (clk),
    .rst   (rst),
    .inc   (MEM_stall),
    .count (frz_count)
  );

  sat_counter #(.W(CNT_W)) u_cnt_bubble (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_D),
    .count (bub_count)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_FD),
    .count (fl_count)
  );

  assign cnt_freeze = rst ? '0 : frz_count;
  assign cnt_bubble = rst ? '0 : bub_count;
  assign cnt_flush  = rst ? '0 : fl_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MUL_LAT 3, 1 and 5) share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] D_rs1, D_rs2, EX_rd;
  logic       D_use_rs1, D_use_rs2, EX_ld, EX_mul, EX_taken, M_req, dmem_ready;

  logic        stall_F, stall_D, flush_FD, MEM_stall;
  logic [15:0] cnt_freeze, cnt_bubble, cnt_flush;
  logic        l1_stall_F, l1_stall_D, l1_flush_FD, l1_MEM_stall;
  logic [1:0]  l1_cnt_freeze, l1_cnt_bubble, l1_cnt_flush;
  logic        l5_stall_F, l5_stall_D, l5_flush_FD, l5_MEM_stall;
  logic [15:0] l5_cnt_freeze, l5_cnt_bubble, l5_cnt_flush;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1),
    .D_use_rs2(D_use_rs2), .EX_ld(EX_ld), .EX_rd(EX_rd), .EX_mul(EX_mul),
    .EX_taken(EX_taken), .M_req(M_req), .dmem_ready(dmem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .flush_FD(flush_FD), .MEM_stall(MEM_stall),
    .cnt_freeze(cnt_freeze), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
  );

  hazard_ctrl #(.MUL_LAT(1), .CNT_W(2)) u_lat1 (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1),
    .D_use_rs2(D_use_rs2), .EX_ld(EX_ld), .EX_rd(EX_rd), .EX_mul(EX_mul),
    .EX_taken(EX_taken), .M_req(M_req), .dmem_ready(dmem_ready),
    .stall_F(l1_stall_F), .stall_D(l1_stall_D), .flush_FD(l1_flush_FD),
    .MEM_stall(l1_MEM_stall), .cnt_freeze(l1_cnt_freeze), .cnt_bubble(l1_cnt_bubble),
    .cnt_flush(l1_cnt_flush)
  );

  hazard_ctrl #(.MUL_LAT(5), .CNT_W(16)) u_lat5 (
    .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1),
    .D_use_rs2(D_use_rs2), .EX_ld(EX_ld), .EX_rd(EX_rd), .EX_mul(EX_mul),
    .EX_taken(EX_taken), .M_req(M_req), .dmem_ready(dmem_ready),
    .stall_F(l5_stall_F), .stall_D(l5_stall_D), .flush_FD(l5_flush_FD),
    .MEM_stall(l5_MEM_stall), .cnt_freeze(l5_cnt_freeze), .cnt_bubble(l5_cnt_bubble),
    .cnt_flush(l5_cnt_flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    D_rs1 = 5'd0; D_rs2 = 5'd0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
    EX_ld = 1'b0; EX_rd = 5'd0; EX_mul = 1'b0; EX_taken = 1'b0;
    M_req = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    // Reset: every output of every instance is zero.
    tick();
    EX_taken = 1'b1;
    #1;
    check("rst_all", 32'({stall_F, stall_D, flush_FD, MEM_stall, cnt_freeze, cnt_bubble, cnt_flush}), 0);
    check("rst_l1", 32'({l1_stall_F, l1_stall_D, l1_flush_FD, l1_MEM_stall,
                         l1_cnt_freeze, l1_cnt_bubble, l1_cnt_flush}), 0);
    check("rst_l5", 32'({l5_stall_F, l5_stall_D, l5_flush_FD, l5_MEM_stall,
                         l5_cnt_freeze, l5_cnt_bubble, l5_cnt_flush}), 0);
    tick();
    rst = 1'b0;
    EX_taken = 1'b0;
    #1;
    check("post_rst_stall", 32'({stall_F, stall_D, flush_FD, MEM_stall}), 0);
    check("post_rst_cnt", 32'(cnt_freeze) + 32'(cnt_bubble) + 32'(cnt_flush), 0);

    // Load-use on rs1, then x0 and rs2 variants.
    EX_ld = 1'b1; EX_rd = 5'd5; D_rs1 = 5'd5; D_use_rs1 = 1'b1;
    #1;
    check("lu_stall_F", 32'(stall_F), 1);
    check("lu_stall_D", 32'(stall_D), 1);
    check("lu_flush", 32'(flush_FD), 0);
    tick();
    EX_ld = 1'b0;
    #1;
    check("lu_drop", 32'({stall_F, stall_D}), 0);
    check("lu_cnt1", 32'(cnt_bubble), 1);
    EX_ld = 1'b1; EX_rd = 5'd0; D_rs1 = 5'd0;
    #1;
    check("lu_x0", 32'({stall_F, stall_D}), 0);
    EX_rd = 5'd7; D_rs1 = 5'd5; D_rs2 = 5'd7; D_use_rs2 = 1'b1; D_use_rs1 = 1'b0;
    #1;
    check("lu_rs2", 32'({stall_F, stall_D}), 3);
    tick();
    clear_inputs();
    #1;
    check("lu_cnt2", 32'(cnt_bubble), 2);

    // Memory miss: 4 not-ready cycles then ready.
    M_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("miss_wait", 32'(MEM_stall), 1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    check("miss_ready", 32'(MEM_stall), 1);
    tick();
    M_req = 1'b0; dmem_ready = 1'b0;
    #1;
    check("miss_done", 32'(MEM_stall), 0);
    tick();
    check("miss_cnt", 32'(cnt_freeze), 5);
    check("sat_cnt", 32'(l1_cnt_freeze), 3);
    M_req = 1'b1; dmem_ready = 1'b1;
    #1;
    check("hit", 32'(MEM_stall), 0);
    tick();
    M_req = 1'b0; dmem_ready = 1'b0;
    #1;
    check("hit_cnt", 32'(cnt_freeze), 5);

    // Multiply hold, then a back-to-back multiply after the first advances.
    EX_mul = 1'b1;
    #1;
    check("mul_c0", 32'(MEM_stall), 1);
    check("mul1_c0", 32'(l1_MEM_stall), 0);
    tick();
    check("mul_c1", 32'(MEM_stall), 1);
    check("mul1_c1", 32'(l1_MEM_stall), 0);
    tick();
    check("mul_c2", 32'(MEM_stall), 0);
    tick();
    check("mul_b2b_c0", 32'(MEM_stall), 1);
    tick();
    check("mul_b2b_c1", 32'(MEM_stall), 1);
    tick();
    EX_mul = 1'b0;
    #1;
    check("mul_end", 32'(MEM_stall), 0);
    tick();
    check("mul_cnt", 32'(cnt_freeze), 9);

    // Multiply overlapping a 4-cycle miss.
    EX_mul = 1'b1; M_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ov_hold", 32'(MEM_stall), 1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    check("ov_ready", 32'(MEM_stall), 1);
    tick();
    dmem_ready = 1'b0;
    #1;
    check("ov_done", 32'(MEM_stall), 0);
    tick();
    EX_mul = 1'b0; M_req = 1'b0;
    #1;
    check("ov_idle", 32'(MEM_stall), 0);
    check("ov_cnt", 32'(cnt_freeze), 13);

    // Redirect arriving during a freeze, released on the first unfrozen cycle.
    M_req = 1'b1; dmem_ready = 1'b0; EX_taken = 1'b1;
    #1;
    check("rd_frz_flush", 32'({flush_FD, stall_D}), 0);
    check("rd_frz_stall", 32'(MEM_stall), 1);
    tick();
    check("rd_wait_flush", 32'(flush_FD), 0);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("rd_ready_flush", 32'(flush_FD), 0);
    tick();
    M_req = 1'b0; dmem_ready = 1'b0;
    EX_ld = 1'b1; EX_rd = 5'd3; D_rs1 = 5'd3; D_use_rs1 = 1'b1;
    #1;
    check("rd_go_stall", 32'(MEM_stall), 0);
    check("rd_go_flush", 32'(flush_FD), 1);
    check("rd_go_stall_D", 32'(stall_D), 1);
    check("rd_lu_stall_F", 32'(stall_F), 0);
    tick();
    clear_inputs();
    #1;
    check("rd_cnt_flush", 32'(cnt_flush), 1);
    check("rd_cnt_bubble", 32'(cnt_bubble), 3);
    check("rd_cnt_freeze", 32'(cnt_freeze), 16);

    // MUL_LAT=5: miss resolves before the multiply; M_DONE must not re-issue.
    EX_mul = 1'b1; M_req = 1'b1; dmem_ready = 1'b0;
    #1;
    check("l5_c0", 32'(l5_MEM_stall), 1);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("l5_c1", 32'(l5_MEM_stall), 1);
    tick();
    dmem_ready = 1'b0;
    #1;
    check("l5_c2", 32'(l5_MEM_stall), 1);
    tick();
    check("l5_c3", 32'(l5_MEM_stall), 1);
    tick();
    check("l5_c4", 32'(l5_MEM_stall), 0);
    tick();
    EX_mul = 1'b0; M_req = 1'b0; dmem_ready = 1'b1;
    tick();
    tick();
    dmem_ready = 1'b0;
    tick();
    tick();

    // Reset in the middle of a multiply hold and a memory wait.
    EX_mul = 1'b1; M_req = 1'b1; dmem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_out", 32'({stall_F, stall_D, flush_FD, MEM_stall}), 0);
    check("mid_rst_cnt", 32'(cnt_freeze), 0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("after_rst_stall", 32'(MEM_stall), 0);
    check("after_rst_cnt", 32'(cnt_freeze) + 32'(cnt_bubble) + 32'(cnt_flush), 0);
    tick();
    check("after_rst_stall2", 32'(MEM_stall), 0);
    EX_taken = 1'b1;
    #1;
    check("after_rst_flush", 32'(flush_FD), 1);
    tick();
    clear_inputs();
    #1;
    check("after_rst_cnt_flush", 32'(cnt_flush), 1);
    check("after_rst_cnt_freeze", 32'(cnt_freeze), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
